// File: rtl/sub_nibble_serial.sv
// rtl/sub_nibble_serial.sv - nibble-serial two's-complement subtractor (a - b) with N/Z/V/C flags
// Optional macro SUB_SAT_EN: clamp diff to the signed limit on overflow.
module sub_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-5:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             fn_q, fn_d, fz_q, fz_d, fv_q, fv_d, fc_q, fc_d;

  logic [3:0]       g, p, s;
  logic [4:0]       c;
  logic [WIDTH-1:0] raw, res;
  logic             ovf;

  // Operands shift right each step so the slice always sees the current nibble in bits [3:0].
  assign g    = a_q[3:0] & nb_q[3:0];
  assign p    = a_q[3:0] ^ nb_q[3:0];
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];
  assign raw  = {s, acc_q};
  assign ovf  = c[3] ^ c[4];

`ifdef SUB_SAT_EN
  // On the last nibble a_q[3] is the minuend sign bit.
  assign res = ovf ? (a_q[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : raw;
`else
  assign res = raw;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    nb_d    = nb_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    fn_d    = fn_q;
    fz_d    = fz_q;
    fv_d    = fv_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        nb_d    = nb_q >> 4;
        acc_d   = raw[WIDTH-1:4];
        carry_d = c[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = S_DONE;
          diff_d  = res;
          fn_d    = res[WIDTH-1];
          fz_d    = (raw == '0);
          fv_d    = ovf;
          fc_d    = c[4];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      nb_q    <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      fn_q    <= 1'b0;
      fz_q    <= 1'b0;
      fv_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      fn_q    <= fn_d;
      fz_q    <= fz_d;
      fv_q    <= fv_d;
      fc_q    <= fc_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign flag_n = fn_q;
  assign flag_z = fz_q;
  assign flag_v = fv_q;
  assign flag_c = fc_q;
endmodule

// File: tb/tb_sub_nibble_serial.sv
// tb/tb_sub_nibble_serial.sv - table-driven scoreboard bench for sub_nibble_serial
module tb_sub_nibble_serial;
  localparam int W = 16;
`ifdef SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, flag_n, flag_z, flag_v, flag_c;
  logic [W-1:0] diff;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  sub_nibble_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .diff(diff),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected_done: got done=1 expected no pending op", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(e.d));
      chk({tag, "_n"}, 32'(flag_n), 32'(e.n));
      chk({tag, "_z"}, 32'(flag_z), 32'(e.z));
      chk({tag, "_v"}, 32'(flag_v), 32'(e.v));
      chk({tag, "_c"}, 32'(flag_c), 32'(e.c));
    end
  endtask

  // Called one negedge after the accepting edge; done is due four negedges later.
  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", tag, k);
    end else begin
      pop_check(tag);
      chk({tag, "_lat"}, 32'(k), 32'd4);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic issue(input vec_t v, input string tag);
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    a_in  = ~v.a;
    b_in  = v.a;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag);
  endtask

  initial begin
    vec_t v;
    int   dones;
    bit   saw;
    tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, SAT, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{16'h7FFF, 16'hFFFF, SAT ? 16'h7FFF : 16'h8000, !SAT, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{16'h8000, 16'h7FFF, SAT ? 16'h8000 : 16'h0001, SAT, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{16'h0000, 16'h8000, SAT ? 16'h7FFF : 16'h8000, !SAT, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{16'h00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({flag_n, flag_z, flag_v, flag_c}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++) issue(tbl[i], $sformatf("vec%0d", i));

    // start held for 10 edges; operands change right after acceptance.
    v = '{16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1};
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    sb.push_back(v);
    dones = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_in = 16'h0010;
        b_in = 16'h0003;
        v = '{16'h0010, 16'h0003, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b1};
        sb.push_back(v);
      end
      if (i == 10) start = 1'b0;
      if (done) begin
        pop_check($sformatf("hold_op%0d", dones));
        dones++;
      end
    end
    chk("hold_done_count", 32'(dones), 32'd2);
    chk("hold_idle", 32'(busy), 32'd0);

    // Abort in RUN with counter=2; diff/flags currently nonzero from the last op.
    a_in  = 16'h4321;
    b_in  = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_flags", 32'({flag_n, flag_z, flag_v, flag_c}), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", 32'(saw), 32'd0);
    issue(tbl[9], "post_reset");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
